// File: rtl/duty_cycle_ctrl.sv
// duty_cycle_ctrl: push-button PWM duty controller.
//   Synchronises and debounces two raw buttons, turns each debounced press into
//   one duty step (saturating at DUTY_MIN/DUTY_MAX), and runs an IDLE/HIGH/LOW
//   phase machine that applies the pending duty only at a period boundary.
// Optional feature macro: AUTOREPEAT_EN (auto-repeat steps every RPT_CYCLES
//   while exactly one button stays pressed). Undefined by default.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   pshbtn_p     - raw "increase duty" button (asynchronous, may bounce)
//   pshbtn_m     - raw "decrease duty" button (asynchronous, may bounce)
//   pwm_out      - registered PWM waveform
//   t_high       - applied duty (HIGH cycles of the current period)
//   t_low        - PERIOD - t_high
//   duty_pending - duty that will be applied at the next period start
//   period_start - one-cycle pulse in the first HIGH cycle of each period
module duty_cycle_ctrl #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned PERIOD    = 20,
    parameter int unsigned DUTY_INIT = 10,
    parameter int unsigned DUTY_MIN  = 1,
    parameter int unsigned DUTY_MAX  = 19,
    parameter int unsigned DB_CYCLES = 4
`ifdef AUTOREPEAT_EN
    ,
    parameter int unsigned RPT_CYCLES = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pshbtn_p,
    input  logic             pshbtn_m,
    output logic             pwm_out,
    output logic [WIDTH-1:0] t_high,
    output logic [WIDTH-1:0] t_low,
    output logic [WIDTH-1:0] duty_pending,
    output logic             period_start
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES);
`ifdef AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(RPT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Bit 0 = plus button, bit 1 = minus button.
    logic [1:0]      s1_q, s1_d;
    logic [1:0]      s2_q, s2_d;
    logic [1:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      rise;
    logic            step_up;
    logic            step_dn;
`ifdef AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    logic [WIDTH-1:0] duty_pending_q, duty_pending_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] t_high_q, t_high_d;
    logic [WIDTH-1:0] t_low_q, t_low_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             enter_high;

    // Synchroniser and debounce: db flips after DB_CYCLES consecutive mismatches.
    always_comb begin
        s1_d = {pshbtn_m, pshbtn_p};
        s2_d = s1_q;
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Step requests: a lone rising edge of a debounced level (plus optional repeat).
    always_comb begin
        rise    = db_d & ~db_q;
        step_up = rise[0] & ~rise[1];
        step_dn = rise[1] & ~rise[0];
`ifdef AUTOREPEAT_EN
        rpt_cnt_d = '0;
        // Count only while exactly one level is held and no fresh edge restarted it.
        if ((rise == 2'b00) && (db_d[0] ^ db_d[1])) begin
            if (rpt_cnt_q == RPT_W'(RPT_CYCLES - 1)) begin
                step_up = db_d[0];
                step_dn = db_d[1];
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
`endif
    end

    // Pending duty with saturation at the configured limits.
    always_comb begin
        duty_pending_d = duty_pending_q;
        if (step_up && (duty_pending_q < WIDTH'(DUTY_MAX))) begin
            duty_pending_d = duty_pending_q + WIDTH'(1);
        end else if (step_dn && (duty_pending_q > WIDTH'(DUTY_MIN))) begin
            duty_pending_d = duty_pending_q - WIDTH'(1);
        end
    end

    // Phase machine; phase_q counts down the remaining cycles of the current phase.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        t_high_d   = t_high_q;
        t_low_d    = t_low_q;
        pwm_d      = pwm_q;
        ps_d       = 1'b0;
        enter_high = 1'b0;
        case (state_q)
            ST_IDLE: enter_high = 1'b1;
            ST_HIGH: begin
                if (phase_q == '0) begin
                    state_d = ST_LOW;
                    phase_d = t_low_q - WIDTH'(1);
                    pwm_d   = 1'b0;
                end else begin
                    phase_d = phase_q - WIDTH'(1);
                end
            end
            ST_LOW: begin
                if (phase_q == '0) begin
                    enter_high = 1'b1;
                end else begin
                    phase_d = phase_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pwm_d   = 1'b0;
            end
        endcase
        // Pre-edge pending value is used, so a step on this same edge waits a period.
        if (enter_high) begin
            state_d  = ST_HIGH;
            t_high_d = duty_pending_q;
            t_low_d  = WIDTH'(PERIOD) - duty_pending_q;
            phase_d  = duty_pending_q - WIDTH'(1);
            pwm_d    = 1'b1;
            ps_d     = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q           <= '0;
            s2_q           <= '0;
            db_q           <= '0;
            db_cnt_q[0]    <= '0;
            db_cnt_q[1]    <= '0;
`ifdef AUTOREPEAT_EN
            rpt_cnt_q      <= '0;
`endif
            duty_pending_q <= WIDTH'(DUTY_INIT);
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            t_high_q       <= WIDTH'(DUTY_INIT);
            t_low_q        <= WIDTH'(PERIOD - DUTY_INIT);
            pwm_q          <= 1'b0;
            ps_q           <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            db_q           <= db_d;
            db_cnt_q[0]    <= db_cnt_d[0];
            db_cnt_q[1]    <= db_cnt_d[1];
`ifdef AUTOREPEAT_EN
            rpt_cnt_q      <= rpt_cnt_d;
`endif
            duty_pending_q <= duty_pending_d;
            state_q        <= state_d;
            phase_q        <= phase_d;
            t_high_q       <= t_high_d;
            t_low_q        <= t_low_d;
            pwm_q          <= pwm_d;
            ps_q           <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign t_high       = t_high_q;
    assign t_low        = t_low_q;
    assign duty_pending = duty_pending_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_duty_cycle_ctrl.sv
// Self-checking bench for duty_cycle_ctrl (default build, AUTOREPEAT_EN undefined).
module tb_duty_cycle_ctrl;

    localparam int WIDTH     = 5;
    localparam int PERIOD    = 20;
    localparam int DUTY_INIT = 10;
    localparam int DUTY_MIN  = 1;
    localparam int DUTY_MAX  = 19;
    localparam int DB_CYCLES = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pshbtn_p = 1'b0;
    logic             pshbtn_m = 1'b0;
    logic             pwm_out;
    logic             period_start;
    logic [WIDTH-1:0] t_high;
    logic [WIDTH-1:0] t_low;
    logic [WIDTH-1:0] duty_pending;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    duty_cycle_ctrl #(
        .WIDTH    (WIDTH),
        .PERIOD   (PERIOD),
        .DUTY_INIT(DUTY_INIT),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pshbtn_p    (pshbtn_p),
        .pshbtn_m    (pshbtn_m),
        .pwm_out     (pwm_out),
        .t_high      (t_high),
        .t_low       (t_low),
        .duty_pending(duty_pending),
        .period_start(period_start)
    );

    // ---------------- behavioural model ----------------
    // Raw samples per edge; the synchronised value seen at edge e is raw(e-2).
    bit hp[$];
    bit hm[$];
    bit m_db_p, m_db_m, m_idle;
    int m_pending, m_applied, m_pos;
    bit chk_on = 1'b0;

    task automatic model_reset();
        hp.delete();
        hm.delete();
        for (int i = 0; i < DB_CYCLES + 2; i++) begin
            hp.push_back(1'b0);
            hm.push_back(1'b0);
        end
        m_db_p    = 1'b0;
        m_db_m    = 1'b0;
        m_idle    = 1'b1;
        m_pending = DUTY_INIT;
        m_applied = DUTY_INIT;
        m_pos     = 0;
    endtask

    // Level flips when the last DB_CYCLES synchronised samples all disagree with it.
    function automatic bit flips(input bit q[$], input bit db);
        int n;
        n = q.size();
        for (int k = 3; k < 3 + DB_CYCLES; k++) begin
            if (q[n-k] == db) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit rp, input bit rm);
        bit old_p, old_m, up, dn;
        int pend_pre;
        pend_pre = m_pending;
        hp.push_back(rp);
        hm.push_back(rm);
        old_p = m_db_p;
        old_m = m_db_m;
        if (flips(hp, m_db_p)) m_db_p = !m_db_p;
        if (flips(hm, m_db_m)) m_db_m = !m_db_m;
        up = m_db_p && !old_p;
        dn = m_db_m && !old_m;
        if (up && !dn && m_pending < DUTY_MAX) m_pending++;
        else if (dn && !up && m_pending > DUTY_MIN) m_pending--;
        if (m_idle) begin
            m_idle    = 1'b0;
            m_pos     = 0;
            m_applied = pend_pre;
        end else begin
            m_pos++;
            if (m_pos == PERIOD) begin
                m_pos     = 0;
                m_applied = pend_pre;
            end
        end
        while (hp.size() > 32) void'(hp.pop_front());
        while (hm.size() > 32) void'(hm.pop_front());
    endtask

    always @(posedge clk) begin
        if (!reset) model_step(pshbtn_p, pshbtn_m);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pwm_out", int'(pwm_out), int'(!m_idle && m_pos < m_applied));
            chk("period_start", int'(period_start), int'(!m_idle && m_pos == 0));
            chk("t_high", int'(t_high), m_applied);
            chk("t_low", int'(t_low), PERIOD - m_applied);
            chk("duty_pending", int'(duty_pending), m_pending);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit p, input bit m, input int hold, input int gap);
        pshbtn_p = p;
        pshbtn_m = m;
        cycles(hold);
        pshbtn_p = 1'b0;
        pshbtn_m = 1'b0;
        cycles(gap);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 2 * PERIOD + 4);
        chk(name, int'(period_start), 1);
    endtask

    initial begin
        int hi, ps_cnt, kind, hold, gap;
        model_reset();
        cycles(2);
        chk_on = 1'b1;
        // Reset values while still in reset.
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_t_high", int'(t_high), 10);
        chk("rst_t_low", int'(t_low), 10);
        reset = 1'b0;

        // Scenario 1: one IDLE cycle, then 10 high / 10 low.
        @(negedge clk);
        chk("s1_first_ps", int'(period_start), 1);
        chk("s1_first_pwm", int'(pwm_out), 1);
        hi = 0;
        ps_cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(pwm_out);
            ps_cnt += int'(period_start);
            @(negedge clk);
        end
        chk("s1_high_count", hi, 10);
        chk("s1_ps_count", ps_cnt, 1);
        chk("s1_ps_again", int'(period_start), 1);

        // Scenario 2: three clean plus presses.
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10, 10);
        chk("s2_pending", int'(duty_pending), 13);
        wait_ps("s2_wait_ps");
        chk("s2_t_high", int'(t_high), 13);
        chk("s2_t_low", int'(t_low), 7);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(pwm_out);
            @(negedge clk);
        end
        chk("s2_high_count", hi, 13);

        // Scenario 3: bouncing every 2 cycles never debounces.
        for (int i = 0; i < 15; i++) begin
            pshbtn_p = ~pshbtn_p;
            cycles(2);
        end
        pshbtn_p = 1'b0;
        cycles(10);
        chk("s3_pending", int'(duty_pending), 13);

        // Scenario 4: saturate at both limits.
        do_reset();
        cycles(3);
        for (int i = 0; i < 12; i++) press(1'b1, 1'b0, 10, 10);
        chk("s4_sat_max", int'(duty_pending), 19);
        wait_ps("s4_wait_ps_max");
        chk("s4_t_low_min", int'(t_low), 1);
        for (int i = 0; i < 25; i++) press(1'b0, 1'b1, 10, 10);
        chk("s4_sat_min", int'(duty_pending), 1);
        wait_ps("s4_wait_ps_min");
        chk("s4_t_high_min", int'(t_high), 1);

        // Scenario 5: simultaneous press ignored; held + new press acts once.
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 10, 10);
        chk("s5_setup", int'(duty_pending), 5);
        press(1'b1, 1'b1, 10, 10);
        chk("s5_both", int'(duty_pending), 5);
        pshbtn_p = 1'b1;
        cycles(10);
        chk("s5_hold_p", int'(duty_pending), 6);
        pshbtn_m = 1'b1;
        cycles(10);
        chk("s5_new_m", int'(duty_pending), 5);
        pshbtn_p = 1'b0;
        pshbtn_m = 1'b0;
        cycles(10);
        chk("s5_release", int'(duty_pending), 5);

        // Scenario 6: asynchronous reset in the middle of HIGH.
        for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 10, 10);
        chk("s6_setup", int'(duty_pending), 15);
        hi = 0;
        while (!(pwm_out && !period_start) && hi < 2 * PERIOD) begin
            @(negedge clk);
            hi++;
        end
        chk("s6_in_high", int'(pwm_out), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("s6_async_pwm", int'(pwm_out), 0);
        chk("s6_async_t_high", int'(t_high), 10);
        chk("s6_async_pending", int'(duty_pending), 10);
        chk("s6_async_ps", int'(period_start), 0);
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        chk("s6_restart_ps", int'(period_start), 1);

        // Randomised presses, releases, bounce and occasional resets.
        for (int it = 0; it < 80; it++) begin
            kind = int'($urandom_range(0, 5));
            hold = int'($urandom_range(1, 14));
            gap  = int'($urandom_range(1, 14));
            if ($urandom_range(0, 24) == 0) do_reset();
            case (kind)
                0, 1: press(1'b1, 1'b0, hold, gap);
                2, 3: press(1'b0, 1'b1, hold, gap);
                4: press(1'b1, 1'b1, hold, gap);
                default: begin
                    for (int j = 0; j < hold; j++) begin
                        pshbtn_p = 1'($urandom_range(0, 1));
                        pshbtn_m = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    pshbtn_p = 1'b0;
                    pshbtn_m = 1'b0;
                    cycles(gap);
                end
            endcase
        end
        cycles(2 * PERIOD);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/duty_cycle_ctrl.md
Name: duty_cycle_ctrl

Overview:
Controller that turns the two raw push-buttons into a PWM waveform.
- Synchronises and debounces each button, then converts each press into a single step request.
- Keeps a pending duty setting with saturation at the configured limits.
- Runs a HIGH/LOW phase state machine and applies the pending duty only at a period boundary.
- Sits between the board buttons and the LED/PWM output pin. Exports t_high/t_low for display logic.

Parameters:
WIDTH, 5, width of duty/phase counters (PERIOD must fit)
PERIOD, 20, PWM period in clk cycles
DUTY_INIT, 10, duty (HIGH cycles) after reset
DUTY_MIN, 1, lowest duty; must be >=1
DUTY_MAX, 19, highest duty; must be <=PERIOD-1
DB_CYCLES, 4, consecutive stable cycles needed to accept a button level change; >=2
RPT_CYCLES, 8, auto-repeat interval (used only with AUTOREPEAT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
pshbtn_p  input  1  raw "increase duty" button, asynchronous, may bounce
pshbtn_m  input  1  raw "decrease duty" button, asynchronous, may bounce
pwm_out  output  1  PWM waveform
t_high  output  WIDTH  applied duty (HIGH cycles of current period)
t_low  output  WIDTH  PERIOD - t_high
duty_pending  output  WIDTH  duty that will be applied at next period start
period_start  output  1  one-cycle pulse in first HIGH cycle of each period

Behaviour:
- Reset (asynchronous, active-high) forces the following immediately, regardless of phase:
  - pwm_out=0, period_start=0.
  - t_high=duty_pending=DUTY_INIT, t_low=PERIOD-DUTY_INIT.
  - Sync flops, debounced levels and all counters cleared to 0; FSM in IDLE.
- Input path, per button:
  - 2-flop synchroniser s1 -> s2.
  - Debounce counter increments on every edge where s2 differs from the debounced level db, and clears when they match.
  - When the counter is at DB_CYCLES-1 and s2 still differs, db toggles and the counter clears.
  - Timing: if raw high is first sampled at edge N and held, db rises at edge N+1+DB_CYCLES. Release behaves symmetrically.
- Step rules:
  - Only a rising edge of db issues a step; duty_pending updates on that same edge.
  - Rising edges of both db_p and db_m on the same edge: no step.
  - One button held while the other is newly pressed: only the new edge acts.
  - Increment at DUTY_MAX or decrement at DUTY_MIN is ignored. Saturate, never wrap.
- FSM: IDLE -> HIGH -> LOW -> HIGH ...
  - IDLE: lasts exactly one cycle after reset release; pwm_out=0.
  - Entry to HIGH (from IDLE, or from the last LOW cycle): duty_act<=duty_pending, t_high/t_low updated, phase counter loaded. period_start=1 for that one cycle.
  - HIGH: pwm_out=1 for exactly duty_act cycles, then LOW.
  - LOW: pwm_out=0 for exactly PERIOD-duty_act cycles, then HIGH.
  - Both phases are always at least 1 cycle, because DUTY_MIN>=1 and DUTY_MAX<=PERIOD-1.
- Period boundary timing:
  - A step landing on the same edge as HIGH entry is not applied until the following period.
  - duty_pending changes mid-period never alter the current period's pwm_out, t_high or t_low.
- pwm_out, t_high, t_low and period_start are all registered; no combinational path from the buttons.

Optional Feature:
AUTOREPEAT_EN
- Defined: while exactly one db level stays high, a further step is issued every RPT_CYCLES cycles, the first one RPT_CYCLES cycles after the initial step. Saturation rules unchanged. The repeat counter clears when db falls or both db levels are high.
- Undefined: exactly one step per press. The repeat counter and RPT_CYCLES logic are absent.

Test Plan:
All scenarios use default parameters, AUTOREPEAT_EN undefined unless stated.
1. Reset, release, no buttons -> IDLE 1 cycle, period_start pulse, then pwm_out high 10 / low 10 repeating. t_high=10, t_low=10.
2. Three clean pshbtn_p presses (each 10 cycles high, 10 low) early in a period -> duty_pending 11, 12, 13, each at edge N+5 of its press. t_high stays 10 until the next period_start, then 13 with t_low=7; pwm_out high 13 / low 7.
3. pshbtn_p toggling every 2 cycles for 30 cycles, then steady low -> db_p never rises; duty_pending stays 10.
4. 12 clean pshbtn_p presses from 10 -> duty_pending saturates at 19, t_low=1 after the boundary. Then 25 pshbtn_m presses -> 1, never 0 or wrapped.
5. Both buttons raw-high on the same cycle -> no change. Then hold pshbtn_p and later press pshbtn_m -> duty_pending decrements once.
6. Reset asserted mid-HIGH with duty_pending=15 -> pwm_out=0 and t_high=10 immediately (asynchronously); sequence restarts per scenario 1. With AUTOREPEAT_EN defined: hold pshbtn_p for 40 cycles -> steps at db rise, +8, +16, +24, +32.
